// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and their *W forms.
// Special operand combinations resolve at issue in one cycle; the rest take one quotient bit per cycle.
package div_pkg;

  typedef enum logic [3:0] {
    OP_DIV  = 4'b0100,
    OP_DIVU = 4'b0101,
    OP_REM  = 4'b0110,
    OP_REMU = 4'b0111
  } md_op_t;

  typedef enum logic [2:0] {
    ST_NONE          = 3'd0,
    ST_ZERO_DIVISOR  = 3'd1,
    ST_OVERFLOW      = 3'd2,
    ST_ZERO_DIVIDEND = 3'd3,
    ST_SHORT_DIV     = 3'd4
  } div_status_t;

endpackage

module div_unit
  import div_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            div_req,
  output logic            div_ready,
  input  logic [3:0]      div_op,
  input  logic            word_op,
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] operand2,
  output logic            result_valid,
  input  logic            result_ready,
  output logic [XLEN-1:0] result,
  output logic [2:0]      div_status
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_FIXUP = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  function automatic logic [63:0] sext32(input logic [63:0] v);
    return {{32{v[31]}}, v[31:0]};
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] v);
    return 64'd0 - v;
  endfunction

  state_t      r_state;
  logic [5:0]  r_cnt;
  logic [63:0] r_rem;
  logic [63:0] r_quo;
  logic [63:0] r_dvsr;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_rem_sel;
  logic        r_word;
  logic [63:0] r_result;
  div_status_t r_status;
  logic        r_valid;
  logic        r_ready;

  logic        w_uns;
  logic        w_rem_sel;
  logic [63:0] w_a_ext;
  logic [63:0] w_b_ext;
  logic        w_sign_a;
  logic        w_sign_b;
  logic [63:0] w_mag_a;
  logic [63:0] w_mag_b;
  logic [63:0] w_min_neg;
  div_status_t w_spec_st;
  logic [63:0] w_spec_q;
  logic [63:0] w_spec_r;
  logic [63:0] w_spec_sel;
  logic [63:0] w_spec_res;
  logic [64:0] w_shift;
  logic        w_ge;
  logic [63:0] w_diff;
  logic [63:0] w_q_fix;
  logic [63:0] w_r_fix;
  logic [63:0] w_fix_sel;
  logic [63:0] w_fix_res;
  logic        w_unused_op;

  assign w_unused_op = ^div_op[3:2];

  // Operand extension, magnitudes and special-case classification of the incoming request
  always_comb begin
    w_uns     = div_op[0];
    w_rem_sel = div_op[1];
    if (word_op) begin
      if (w_uns) begin
        w_a_ext = {32'd0, operand1[31:0]};
        w_b_ext = {32'd0, operand2[31:0]};
      end else begin
        w_a_ext = sext32(operand1);
        w_b_ext = sext32(operand2);
      end
      w_min_neg = 64'hFFFF_FFFF_8000_0000;
    end else begin
      w_a_ext   = operand1;
      w_b_ext   = operand2;
      w_min_neg = 64'h8000_0000_0000_0000;
    end

    // after extension, bit 63 carries the W-bit sign for both widths
    w_sign_a = ~w_uns & w_a_ext[63];
    w_sign_b = ~w_uns & w_b_ext[63];
    w_mag_a  = w_sign_a ? neg64(w_a_ext) : w_a_ext;
    w_mag_b  = w_sign_b ? neg64(w_b_ext) : w_b_ext;

    w_spec_st = ST_NONE;
    w_spec_q  = 64'd0;
    w_spec_r  = 64'd0;
    if (w_b_ext == 64'd0) begin
      w_spec_st = ST_ZERO_DIVISOR;
      w_spec_q  = 64'hFFFF_FFFF_FFFF_FFFF;
      w_spec_r  = w_a_ext;
    end else if (!w_uns && (w_a_ext == w_min_neg) && (w_b_ext == 64'hFFFF_FFFF_FFFF_FFFF)) begin
      w_spec_st = ST_OVERFLOW;
      w_spec_q  = w_a_ext;
      w_spec_r  = 64'd0;
    end else if (w_a_ext == 64'd0) begin
      w_spec_st = ST_ZERO_DIVIDEND;
      w_spec_q  = 64'd0;
      w_spec_r  = 64'd0;
    end else if (w_mag_b > w_mag_a) begin
      w_spec_st = ST_SHORT_DIV;
      w_spec_q  = 64'd0;
      w_spec_r  = w_a_ext;
    end else begin
      w_spec_st = ST_NONE;
      w_spec_q  = 64'd0;
      w_spec_r  = 64'd0;
    end

    w_spec_sel = w_rem_sel ? w_spec_r : w_spec_q;
    w_spec_res = word_op ? sext32(w_spec_sel) : w_spec_sel;
  end

  // One restoring step plus the sign/width fixup of the finished quotient and remainder
  always_comb begin
    // 65-bit partial remainder: an unsigned divisor near 2^64 can make the shifted value overflow 64 bits
    w_shift   = {r_rem, r_quo[63]};
    w_ge      = (w_shift >= {1'b0, r_dvsr});
    w_diff    = w_shift[63:0] - r_dvsr;
    w_q_fix   = r_neg_q ? neg64(r_quo) : r_quo;
    w_r_fix   = r_neg_r ? neg64(r_rem) : r_rem;
    w_fix_sel = r_rem_sel ? w_r_fix : w_q_fix;
    w_fix_res = r_word ? sext32(w_fix_sel) : w_fix_sel;
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= 6'd0;
      r_rem     <= 64'd0;
      r_quo     <= 64'd0;
      r_dvsr    <= 64'd0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_rem_sel <= 1'b0;
      r_word    <= 1'b0;
      r_result  <= 64'd0;
      r_status  <= ST_NONE;
      r_valid   <= 1'b0;
      r_ready   <= 1'b1;
    end else if (flush) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (div_req) begin
            r_rem_sel <= w_rem_sel;
            r_word    <= word_op;
            r_neg_q   <= w_sign_a ^ w_sign_b;
            r_neg_r   <= w_sign_a;
            r_dvsr    <= w_mag_b;
            r_rem     <= 64'd0;
            r_ready   <= 1'b0;
            if (w_spec_st != ST_NONE) begin
              r_result <= w_spec_res;
              r_status <= w_spec_st;
              r_valid  <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              // word dividends sit in the upper half so 32 shifts consume exactly their bits
              r_quo   <= word_op ? {w_mag_a[31:0], 32'd0} : w_mag_a;
              r_cnt   <= word_op ? 6'd31 : 6'd63;
              r_state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          r_rem <= w_ge ? w_diff : w_shift[63:0];
          r_quo <= {r_quo[62:0], w_ge};
          if (r_cnt == 6'd0) begin
            r_state <= S_FIXUP;
          end else begin
            r_cnt <= r_cnt - 6'd1;
          end
        end
        S_FIXUP: begin
          r_result <= w_fix_res;
          r_status <= ST_NONE;
          r_valid  <= 1'b1;
          r_state  <= S_DONE;
        end
        S_DONE: begin
          if (result_ready) begin
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign div_ready    = r_ready;
  assign result_valid = r_valid;
  assign result       = r_result;
  assign div_status   = r_status;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed scenarios plus randomized ops against
// an arithmetic reference model built on native SystemVerilog division.
module tb_div_unit;
  import div_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        div_req;
  logic        div_ready;
  logic [3:0]  div_op;
  logic        word_op;
  logic [63:0] operand1;
  logic [63:0] operand2;
  logic        result_valid;
  logic        result_ready;
  logic [63:0] result;
  logic [2:0]  div_status;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] last_res;

  always #5 clk = ~clk;

  div_unit #(.XLEN(64)) dut (
    .clk(clk), .reset(reset), .flush(flush), .div_req(div_req), .div_ready(div_ready),
    .div_op(div_op), .word_op(word_op), .operand1(operand1), .operand2(operand2),
    .result_valid(result_valid), .result_ready(result_ready), .result(result),
    .div_status(div_status)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: RISC-V division semantics from plain arithmetic on extended operands.
  function automatic void model(input logic [3:0] op, input logic word, input logic [63:0] a,
                                input logic [63:0] b, output logic [63:0] res, output logic [2:0] st);
    logic uns, remsel;
    logic [63:0] ae, be, ma, mb, minv, q, r;
    longint sa, sb;
    uns    = (op == OP_DIVU) || (op == OP_REMU);
    remsel = (op == OP_REM) || (op == OP_REMU);
    if (word) begin
      ae   = uns ? {32'd0, a[31:0]} : {{32{a[31]}}, a[31:0]};
      be   = uns ? {32'd0, b[31:0]} : {{32{b[31]}}, b[31:0]};
      minv = 64'hFFFF_FFFF_8000_0000;
    end else begin
      ae   = a;
      be   = b;
      minv = 64'h8000_0000_0000_0000;
    end
    sa = ae;
    sb = be;
    ma = (!uns && sa < 0) ? 64'(-sa) : ae;
    mb = (!uns && sb < 0) ? 64'(-sb) : be;
    if (be == 64'd0) begin
      st = ST_ZERO_DIVISOR; q = 64'hFFFF_FFFF_FFFF_FFFF; r = ae;
    end else if (!uns && ae == minv && sb == -64'sd1) begin
      st = ST_OVERFLOW; q = ae; r = 64'd0;
    end else if (ae == 64'd0) begin
      st = ST_ZERO_DIVIDEND; q = 64'd0; r = 64'd0;
    end else if (mb > ma) begin
      st = ST_SHORT_DIV; q = 64'd0; r = ae;
    end else begin
      st = ST_NONE;
      if (uns) begin
        q = ae / be; r = ae % be;
      end else begin
        q = 64'(sa / sb); r = 64'(sa % sb);
      end
    end
    res = remsel ? r : q;
    if (word) res = {{32{res[31]}}, res[31:0]};
  endfunction

  task automatic wait_result(input string tag, input logic [63:0] er, input logic [2:0] es,
                             input int elat, input int stall);
    int lat;
    logic [63:0] held_r;
    logic [2:0]  held_s;
    lat = 1;
    while (result_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(elat));
    chk({tag, "_res"}, result, er);
    chk({tag, "_st"}, 64'(div_status), 64'(es));
    last_res = result;
    held_r = result;
    held_s = div_status;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_res"}, result, held_r);
      chk({tag, "_hold_ctl"}, {59'd0, div_status, result_valid, div_ready}, {59'd0, held_s, 1'b1, 1'b0});
    end
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    chk({tag, "_rel"}, {62'd0, result_valid, div_ready}, 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic word,
                        input logic [63:0] a, input logic [63:0] b, input int stall);
    logic [63:0] er;
    logic [2:0]  es;
    int n;
    model(op, word, a, b, er, es);
    n = 0;
    while (div_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    div_op = op; word_op = word; operand1 = a; operand2 = b; div_req = 1'b1;
    @(posedge clk); #1;
    div_req  = 1'b0;
    operand1 = {$urandom, $urandom};
    operand2 = {$urandom, $urandom};
    div_op   = 4'($urandom);
    word_op  = 1'($urandom_range(0, 1));
    wait_result(tag, er, es, (es == ST_NONE) ? (word ? 34 : 66) : 1, stall);
  endtask

  function automatic logic [63:0] pick(input logic word);
    logic [63:0] v;
    case ($urandom_range(0, 7))
      0: v = 64'd0;
      1: v = 64'hFFFF_FFFF_FFFF_FFFF;
      2: v = word ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000;
      3: v = 64'($urandom_range(1, 20));
      4: v = {32'd0, $urandom};
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  initial begin
    logic [63:0] er;
    logic [2:0]  es;
    logic [3:0]  ops [4];
    ops[0] = OP_DIV; ops[1] = OP_DIVU; ops[2] = OP_REM; ops[3] = OP_REMU;
    reset = 1'b1; flush = 1'b0; div_req = 1'b0; div_op = OP_DIV; word_op = 1'b0;
    operand1 = 64'd0; operand2 = 64'd0; result_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctl", {59'd0, div_status, result_valid, div_ready}, 64'd1);
    chk("rst_res", result, 64'd0);
    reset = 1'b0;

    run_op("div_m100_7", OP_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 0);
    chk("div_m100_7_lit", last_res, 64'hFFFF_FFFF_FFFF_FFF2);
    run_op("rem_m100_7", OP_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 0);
    chk("rem_m100_7_lit", last_res, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op("divu_by0", OP_DIVU, 1'b0, 64'h1234, 64'd0, 0);
    chk("divu_by0_lit", last_res, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("rem_ovf", OP_REM, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    chk("rem_ovf_lit", last_res, 64'd0);
    run_op("div_zdd", OP_DIV, 1'b0, 64'd0, 64'd5, 0);
    run_op("remu_short", OP_REMU, 1'b0, 64'd3, 64'd10, 0);
    chk("remu_short_lit", last_res, 64'd3);
    run_op("divw_ovf", OP_DIV, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'h0000_0000_FFFF_FFFF, 0);
    chk("divw_ovf_lit", last_res, 64'hFFFF_FFFF_8000_0000);
    run_op("divuw", OP_DIVU, 1'b1, 64'h0000_0001_FFFF_FFFE, 64'd2, 0);
    chk("divuw_lit", last_res, 64'h0000_0000_7FFF_FFFF);
    run_op("divuw_by0", OP_DIVU, 1'b1, 64'h55, 64'hFFFF_FFFF_0000_0000, 0);
    chk("divuw_by0_lit", last_res, 64'hFFFF_FFFF_FFFF_FFFF);

    // backpressure, then a request straight after release
    run_op("bp", OP_DIVU, 1'b0, 64'd1000, 64'd7, 10);
    run_op("bp_next", OP_REM, 1'b0, 64'd1000, 64'd7, 0);

    // flush 20 cycles into a 64-bit divide
    div_op = OP_DIV; word_op = 1'b0; operand1 = 64'd999; operand2 = 64'd4; div_req = 1'b1;
    @(posedge clk); #1;
    div_req = 1'b0;
    repeat (19) begin @(posedge clk); #1; end
    chk("fl_busy", {62'd0, result_valid, div_ready}, 64'd0);
    flush = 1'b1; div_req = 1'b1; div_op = OP_DIV; operand1 = 64'd50; operand2 = 64'd5;
    @(posedge clk); #1;
    chk("fl_idle", {62'd0, result_valid, div_ready}, 64'd1);
    @(posedge clk); #1;
    chk("fl_req_ignored", {62'd0, result_valid, div_ready}, 64'd1);
    flush = 1'b0;
    @(posedge clk); #1;
    chk("fl_req_accepted", {62'd0, result_valid, div_ready}, 64'd0);
    div_req = 1'b0;
    model(OP_DIV, 1'b0, 64'd50, 64'd5, er, es);
    wait_result("fl_after", er, es, 66, 0);

    // reset in the middle of BUSY
    div_op = OP_DIVU; word_op = 1'b0; operand1 = 64'hFFFF; operand2 = 64'd3; div_req = 1'b1;
    @(posedge clk); #1;
    div_req = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_busy_ctl", {59'd0, div_status, result_valid, div_ready}, 64'd1);
    chk("rst_busy_res", result, 64'd0);
    run_op("post_rst", OP_DIV, 1'b0, 64'd77, 64'd7, 0);

    for (int k = 0; k < 40; k++) begin
      logic w;
      w = 1'($urandom_range(0, 1));
      run_op($sformatf("rnd%0d", k), ops[$urandom_range(0, 3)], w, pick(w), pick(w),
             $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative radix-2 integer divider for the RV64M execute stage. It consumes `div_instr` operations issued by decode and returns quotient or remainder, plus a `div_status_t` code, to the writeback mux. Special cases are detected at issue and complete in one cycle. Normal operands take one quotient bit per cycle, covering both 64-bit and word (`*W`) ops.

## Interface
- `XLEN`, 64: datapath width; only 64 is supported.
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `flush` in 1: kills any in-flight operation (branch mispredict / trap).
- `div_req` in 1: request valid.
- `div_ready` out 1: unit idle and able to accept.
- `div_op` in 4: `md_op_t`; only OP_DIV, OP_DIVU, OP_REM, OP_REMU are legal.
- `word_op` in 1: operate on bits [31:0] and sign-extend the result (DIVW/DIVUW/REMW/REMUW).
- `operand1` in XLEN: dividend (rs1).
- `operand2` in XLEN: divisor (rs2).
- `result_valid` out 1: result held and valid.
- `result_ready` in 1: consumer accepts the result.
- `result` out XLEN: quotient or remainder.
- `div_status` out 3: `div_status_t` for the held result.

## Operation
- **States:** IDLE, BUSY, FIXUP, DONE.
- **Accept:** a request is accepted on an edge where state is IDLE, `div_req` = 1 and `flush` = 0. `div_ready` = (state == IDLE).
- **Op decode:** `div_op[0]` = unsigned; `div_op[1]` = remainder select.
- **Operand preparation:**
  - Word op: operands are sign-extended (signed op) or zero-extended (unsigned op) from bit 31.
  - Width W = 32 for word ops, 64 otherwise.
  - Signed ops take the magnitude of each operand; `neg_q` = sign(a) XOR sign(b); `neg_r` = sign(a).
- **Special cases:** evaluated combinationally on the inputs at accept, in priority order. The first match sets the status and a precomputed result, and the next state is DONE.
  - ZERO_DIVISOR: divisor == 0. Quotient = all ones; remainder = dividend.
  - OVERFLOW: signed op, dividend = most-negative W-bit value, divisor = -1. Quotient = dividend; remainder = 0.
  - ZERO_DIVIDEND: dividend == 0. Quotient = 0; remainder = 0.
  - SHORT_DIV: |divisor| > |dividend| (unsigned compare). Quotient = 0; remainder = dividend (original signed value).
  - NONE: none of the above. Next state is BUSY with counter = W-1.
- **BUSY (restoring divide, one bit per cycle):**
  - {rem, quo} shift left by 1.
  - trial = rem − |divisor|.
  - If trial ≥ 0, rem = trial and quo[0] = 1.
  - When counter == 0, go to FIXUP; otherwise decrement the counter.
- **FIXUP:**
  - Apply `neg_q` to the quotient and `neg_r` to the remainder (two's complement).
  - Select the quotient or remainder.
  - For word ops, sign-extend bit 31 into [63:32].
  - Go to DONE.
- **DONE:** `result_valid` = 1; `result` and `div_status` are stable. Leave for IDLE on `result_ready` = 1.
- **Word-op special-case results:** also sign-extended from bit 31. Example: DIVUW by 0 returns 0xFFFF_FFFF_FFFF_FFFF.
- **Flush:** from any state, the next state is IDLE. `result_valid` deasserts the next cycle, and no result is produced for the killed op. Flush with `div_req` in the same cycle: flush wins and the request is not accepted.
- **Reset:** from any state, including mid-BUSY, the next state is IDLE. Counter and all datapath registers clear.

## Timing
- **Reset values:** `div_ready` = 1, `result_valid` = 0, `result` = 0, `div_status` = NONE (3'b000).
- **Special-case latency:** accepted at edge T, `result_valid` = 1 in the cycle after T (1 cycle).
- **Normal latency:** BUSY for W cycles, then FIXUP for 1 cycle, then DONE. `result_valid` rises W+2 cycles after accept: 66 cycles for 64-bit ops, 34 for word ops.
- **Back-to-back:** DONE→IDLE costs one cycle. A new request can be accepted at the earliest on the edge after the one where `result_ready` is sampled high.
- **Stalls:** `result_valid` stays asserted with `result` and `div_status` stable while `result_ready` = 0, for any number of cycles.
- **Inputs:** `div_op`, `word_op` and the operands are sampled only on the accept edge and may change afterwards.

## Test plan
- **Signed 64-bit DIV:** DIV −100 / 7 → `result` = −14 (0xFFFF_FFFF_FFFF_FFF2), status NONE, `result_valid` 66 cycles after accept. REM of the same operands → −2.
- **Special cases, 1-cycle latency each:**
  - DIVU 0x1234 / 0 → 0xFFFF_FFFF_FFFF_FFFF, ZERO_DIVISOR.
  - REM 0x8000_0000_0000_0000 / −1 → 0, OVERFLOW.
  - DIV 0 / 5 → 0, ZERO_DIVIDEND.
  - REMU 3 / 10 → 3, SHORT_DIV.
- **Word ops:**
  - DIVW 0xFFFF_FFFF_8000_0000 / 0xFFFF_FFFF → 0xFFFF_FFFF_8000_0000, OVERFLOW.
  - DIVUW 0x0000_0001_FFFF_FFFE / 2 → 0x0000_0000_7FFF_FFFF, latency 34.
- **Backpressure:** hold `result_ready` = 0 for 10 cycles after `result_valid` rises. `result` and `div_status` stay unchanged and `div_ready` stays 0. Release, and a second request is accepted the following cycle.
- **Flush mid-operation:** assert `flush` 20 cycles into a 64-bit DIV. The unit returns to IDLE next cycle and no `result_valid` appears. A new request issued with `flush` high is ignored; issued one cycle later, it is accepted.
- **Reset mid-BUSY:** reset asserted during BUSY → next cycle `div_ready` = 1, `result_valid` = 0, `result` = 0, `div_status` = NONE.
